// File: rtl/cpu_datapath_param.sv
// cpu_datapath_param: parametrised CPU data path. Holds the register file and
// PC, latches per-instruction selects on accept, hands operands to an external
// execute unit over a req/ack handshake, then writes back and updates the PC.
// Optional build macro: CPU_DP_EXU_TIMEOUT_EN enables a watchdog that aborts
// an EXEC phase after EXU_TIMEOUT cycles without exu_ack.
//
// state | meaning
// IDLE  | waiting for an instruction, instr_ready high
// READ  | operands registered from rf / PC / IR
// EXEC  | exu_req held with stable operands until exu_ack (or watchdog abort)
// WB    | retire pulse, rf writeback and PC update

module cpu_datapath_param #(
   parameter int              DATA_W      = 16,
   parameter int              NUM_REGS    = 8,
   parameter int              PC_W        = 16,
   parameter logic [PC_W-1:0] PC_RESET    = '0,
   parameter int              EXU_TIMEOUT = 255,
   localparam int             REG_SEL_W   = $clog2(NUM_REGS)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 instr_valid,
   output logic                 instr_ready,
   input  logic [DATA_W-1:0]    ir,
   input  logic [REG_SEL_W-1:0] rd_sel,
   input  logic [REG_SEL_W-1:0] rs1_sel,
   input  logic [REG_SEL_W-1:0] rs2_sel,
   input  logic                 r1_pc_sel,
   input  logic                 r2_ir_sel,
   input  logic                 pc_alu_sel,
   input  logic                 wb_src_sel,
   input  logic                 wb_en,
   input  logic [2:0]           alu_op,
   output logic                 exu_req,
   output logic [2:0]           exu_op,
   output logic [DATA_W-1:0]    exu_a,
   output logic [DATA_W-1:0]    exu_b,
   input  logic                 exu_ack,
   input  logic [DATA_W-1:0]    exu_result,
   input  logic [DATA_W-1:0]    mem_data,
   output logic [PC_W-1:0]      pc,
   output logic                 busy,
   output logic                 retire,
   output logic                 exu_timeout
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_e;

   state_e                 state_q;
   logic                   instr_ready_q, busy_q, retire_q, exu_req_q;
   logic [DATA_W-1:0]      ir_q, exu_a_q, exu_b_q, result_q;
   logic [REG_SEL_W-1:0]   rd_q, rs1_q, rs2_q;
   logic                   r1_pc_q, r2_ir_q, pc_alu_q, wb_src_q, wb_en_q;
   logic [2:0]             exu_op_q;
   logic [PC_W-1:0]        pc_q;
   logic [DATA_W-1:0]      rf_q [NUM_REGS];

   logic [DATA_W-1:0]      rs1_val, rs2_val, op_a, op_b, wb_data, pc_as_data;
   logic [PC_W-1:0]        result_as_pc, pc_next;
   logic                   aborted;

   // PC <-> data width adaptation: zero-extend or truncate as needed
   if (PC_W == DATA_W) begin : g_pc_eq
      assign pc_as_data   = pc_q;
      assign result_as_pc = result_q;
   end else if (PC_W > DATA_W) begin : g_pc_wide
      assign pc_as_data   = pc_q[DATA_W-1:0];
      assign result_as_pc = {{(PC_W-DATA_W){1'b0}}, result_q};
   end else begin : g_pc_narrow
      assign pc_as_data   = {{(DATA_W-PC_W){1'b0}}, pc_q};
      assign result_as_pc = result_q[PC_W-1:0];
   end

`ifdef CPU_DP_EXU_TIMEOUT_EN
   localparam int TMO_W = $clog2(EXU_TIMEOUT + 1);
   logic [TMO_W-1:0] tmo_cnt_q;
   logic             abort_q, timeout_q;
   assign aborted     = abort_q;
   assign exu_timeout = timeout_q;
`else
   logic unused_tmo;
   assign unused_tmo  = (EXU_TIMEOUT > 0);
   assign aborted     = 1'b0;
   assign exu_timeout = 1'b0;
`endif

   // Operand, writeback and next-PC muxes driven only from latched selects;
   // indices beyond the populated depth read as zero
   always_comb begin
      rs1_val = '0;
      rs2_val = '0;
      if (int'(rs1_q) < NUM_REGS) rs1_val = rf_q[rs1_q];
      if (int'(rs2_q) < NUM_REGS) rs2_val = rf_q[rs2_q];
      op_a    = r1_pc_q ? pc_as_data : rs1_val;
      op_b    = r2_ir_q ? ir_q : rs2_val;
      wb_data = wb_src_q ? result_q : mem_data;
      pc_next = (pc_alu_q && !aborted) ? result_as_pc : pc_q + PC_W'(1);
   end

   // Instruction sequencer, register file and PC
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         instr_ready_q <= 1'b0;
         busy_q        <= 1'b0;
         retire_q      <= 1'b0;
         exu_req_q     <= 1'b0;
         exu_op_q      <= '0;
         exu_a_q       <= '0;
         exu_b_q       <= '0;
         result_q      <= '0;
         ir_q          <= '0;
         rd_q          <= '0;
         rs1_q         <= '0;
         rs2_q         <= '0;
         r1_pc_q       <= 1'b0;
         r2_ir_q       <= 1'b0;
         pc_alu_q      <= 1'b0;
         wb_src_q      <= 1'b0;
         wb_en_q       <= 1'b0;
         pc_q          <= PC_RESET;
         for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
`ifdef CPU_DP_EXU_TIMEOUT_EN
         tmo_cnt_q     <= '0;
         abort_q       <= 1'b0;
         timeout_q     <= 1'b0;
`endif
      end else begin
         retire_q <= 1'b0;
`ifdef CPU_DP_EXU_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (instr_valid && instr_ready_q) begin
                  ir_q          <= ir;
                  rd_q          <= rd_sel;
                  rs1_q         <= rs1_sel;
                  rs2_q         <= rs2_sel;
                  r1_pc_q       <= r1_pc_sel;
                  r2_ir_q       <= r2_ir_sel;
                  pc_alu_q      <= pc_alu_sel;
                  wb_src_q      <= wb_src_sel;
                  wb_en_q       <= wb_en;
                  exu_op_q      <= alu_op;
                  instr_ready_q <= 1'b0;
                  busy_q        <= 1'b1;
                  state_q       <= S_READ;
               end else begin
                  instr_ready_q <= 1'b1;
               end
            end
            S_READ: begin
               exu_a_q   <= op_a;
               exu_b_q   <= op_b;
               exu_req_q <= 1'b1;
               state_q   <= S_EXEC;
`ifdef CPU_DP_EXU_TIMEOUT_EN
               tmo_cnt_q <= TMO_W'(EXU_TIMEOUT - 1);
`endif
            end
            S_EXEC: begin
               if (exu_req_q && exu_ack) begin
                  result_q  <= exu_result;
                  exu_req_q <= 1'b0;
                  retire_q  <= 1'b1;
                  state_q   <= S_WB;
               end
`ifdef CPU_DP_EXU_TIMEOUT_EN
               else if (tmo_cnt_q == '0) begin
                  exu_req_q <= 1'b0;
                  abort_q   <= 1'b1;
                  timeout_q <= 1'b1;
                  retire_q  <= 1'b1;
                  state_q   <= S_WB;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q - TMO_W'(1);
               end
`endif
            end
            S_WB: begin
               if (wb_en_q && !aborted && (int'(rd_q) < NUM_REGS)) rf_q[rd_q] <= wb_data;
               pc_q          <= pc_next;
               busy_q        <= 1'b0;
               instr_ready_q <= 1'b1;
               state_q       <= S_IDLE;
`ifdef CPU_DP_EXU_TIMEOUT_EN
               abort_q       <= 1'b0;
`endif
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign instr_ready = instr_ready_q;
   assign exu_req     = exu_req_q;
   assign exu_op      = exu_op_q;
   assign exu_a       = exu_a_q;
   assign exu_b       = exu_b_q;
   assign pc          = pc_q;
   assign busy        = busy_q;
   assign retire      = retire_q;

endmodule

// File: tb/tb_cpu_datapath_param.sv
// Directed bench for cpu_datapath_param (6-entry register file so that
// indices 6 and 7 are out of range).
module tb_cpu_datapath_param;
   localparam int DW = 16;
   localparam int SW = 3;
   localparam int PW = 16;

   logic          clk, reset_n, instr_valid, instr_ready;
   logic [DW-1:0] ir, exu_a, exu_b, exu_result, mem_data;
   logic [SW-1:0] rd_sel, rs1_sel, rs2_sel;
   logic          r1_pc_sel, r2_ir_sel, pc_alu_sel, wb_src_sel, wb_en;
   logic [2:0]    alu_op, exu_op;
   logic          exu_req, exu_ack, busy, retire, exu_timeout;
   logic [PW-1:0] pc;

   int            checks, errors;
   logic [15:0]   pc_exp;

   // observations captured by run_instr
   logic          rdy_acc, req_exec, ret_wb, req_wb, rdy_end, ret_end;
   logic [15:0]   oa, ob;
   logic [2:0]    oop;
   bit            ostable;

   cpu_datapath_param #(
      .DATA_W(DW), .NUM_REGS(6), .PC_W(PW), .PC_RESET(16'h0000), .EXU_TIMEOUT(8)
   ) dut (
      .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .ir(ir), .rd_sel(rd_sel), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
      .r1_pc_sel(r1_pc_sel), .r2_ir_sel(r2_ir_sel), .pc_alu_sel(pc_alu_sel),
      .wb_src_sel(wb_src_sel), .wb_en(wb_en), .alu_op(alu_op),
      .exu_req(exu_req), .exu_op(exu_op), .exu_a(exu_a), .exu_b(exu_b),
      .exu_ack(exu_ack), .exu_result(exu_result), .mem_data(mem_data),
      .pc(pc), .busy(busy), .retire(retire), .exu_timeout(exu_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One full instruction; selects are scrambled after accept to prove latching
   task automatic run_instr(input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
                            input logic r1pc, input logic r2ir, input logic pcalu,
                            input logic wbsrc, input logic wben, input logic [2:0] op,
                            input logic [15:0] irw, input int ack_dly,
                            input logic [15:0] res, input bit stray);
      rd_sel = rd; rs1_sel = rs1; rs2_sel = rs2; r1_pc_sel = r1pc; r2_ir_sel = r2ir;
      pc_alu_sel = pcalu; wb_src_sel = wbsrc; wb_en = wben; alu_op = op; ir = irw;
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      rd_sel = ~rd; rs1_sel = ~rs1; rs2_sel = ~rs2; r1_pc_sel = ~r1pc; r2_ir_sel = ~r2ir;
      pc_alu_sel = ~pcalu; wb_src_sel = ~wbsrc; wb_en = ~wben; alu_op = ~op; ir = ~irw;
      rdy_acc = instr_ready;
      if (stray) begin exu_ack = 1'b1; exu_result = 16'hBAD0; end
      @(posedge clk); #1;
      exu_ack = 1'b0;
      req_exec = exu_req; oa = exu_a; ob = exu_b; oop = exu_op; ostable = 1'b1;
      for (int i = 0; i < ack_dly; i++) begin
         @(posedge clk); #1;
         if (exu_req !== 1'b1 || exu_a !== oa || exu_b !== ob || exu_op !== oop ||
             retire !== 1'b0 || exu_timeout !== 1'b0) ostable = 1'b0;
      end
      exu_ack = 1'b1; exu_result = res;
      @(posedge clk); #1;
      exu_ack = 1'b0; exu_result = 16'h5A5A;
      ret_wb = retire; req_wb = exu_req;
      @(posedge clk); #1;
      rdy_end = instr_ready; ret_end = retire;
   endtask

   // Read a register through both operand ports (no writeback, pc+1)
   task automatic read_reg(input logic [2:0] idx, output logic [15:0] va, output logic [15:0] vb);
      run_instr(3'd0, idx, idx, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 0, 16'h0000, 1'b0);
      va = oa; vb = ob;
      pc_exp = pc_exp + 16'd1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; instr_valid = 1'b0; exu_ack = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      pc_exp = 16'h0000;
   endtask

   task automatic test_reset();
      logic [15:0] va, vb;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL rst_pc: got %h exp 0000", pc); end
      checks++; if (exu_req !== 1'b0) begin errors++; $display("FAIL rst_exu_req: got %b exp 0", exu_req); end
      checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b exp 0", instr_ready); end
      checks++; if ({busy, retire, exu_timeout, exu_op} !== 6'd0 || exu_a !== 16'd0 || exu_b !== 16'd0) begin
         errors++; $display("FAIL rst_outputs: busy/retire/tmo/op %b%b%b%h a %h b %h exp all 0", busy, retire, exu_timeout, exu_op, exu_a, exu_b); end
      reset_n = 1'b1;
      @(negedge clk);
      checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_before_edge: got %b exp 0", instr_ready); end
      @(posedge clk); #1;
      checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after_edge: got %b exp 1", instr_ready); end
      pc_exp = 16'h0000;
      for (int i = 0; i < 8; i++) begin
         read_reg(3'(i), va, vb);
         checks++; if (va !== 16'h0000 || vb !== 16'h0000) begin errors++; $display("FAIL rst_rf%0d: got a %h b %h exp 0000", i, va, vb); end
      end
   endtask

   task automatic test_load();
      logic [15:0] va, vb;
      do_reset();
      mem_data = 16'h1234;
      run_instr(3'd3, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 16'h0000, 0, 16'hEEEE, 1'b0);
      checks++; if (rdy_acc !== 1'b0) begin errors++; $display("FAIL load_ready_after_accept: got %b exp 0", rdy_acc); end
      checks++; if (req_exec !== 1'b1) begin errors++; $display("FAIL load_req_t2: got %b exp 1", req_exec); end
      checks++; if (ret_wb !== 1'b1 || req_wb !== 1'b0) begin errors++; $display("FAIL load_retire_t3: retire %b req %b exp 1 0", ret_wb, req_wb); end
      checks++; if (rdy_end !== 1'b1 || ret_end !== 1'b0) begin errors++; $display("FAIL load_idle_t4: ready %b retire %b exp 1 0", rdy_end, ret_end); end
      checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL load_pc: got %h exp 0001", pc); end
      pc_exp = 16'h0001;
      read_reg(3'd3, va, vb);
      checks++; if (va !== 16'h1234 || vb !== 16'h1234) begin errors++; $display("FAIL load_rf3: got a %h b %h exp 1234", va, vb); end
   endtask

   task automatic test_alu_add();
      logic [15:0] va, vb;
      mem_data = 16'h0005;
      run_instr(3'd1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 16'h0000, 0, 16'hEEEE, 1'b0);
      pc_exp = pc_exp + 16'd1;
      run_instr(3'd2, 3'd1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 16'h0007, 4, 16'd12, 1'b1);
      checks++; if (oa !== 16'd5 || ob !== 16'd7 || oop !== 3'b010) begin errors++; $display("FAIL add_operands: got a %h b %h op %h exp 0005 0007 2", oa, ob, oop); end
      checks++; if (ostable !== 1'b1) begin errors++; $display("FAIL add_stable: got %b exp 1", ostable); end
      checks++; if (ret_wb !== 1'b1) begin errors++; $display("FAIL add_retire: got %b exp 1", ret_wb); end
      checks++; if (pc !== pc_exp + 16'd1) begin errors++; $display("FAIL add_pc: got %h exp %h", pc, pc_exp + 16'd1); end
      pc_exp = pc_exp + 16'd1;
      read_reg(3'd2, va, vb);
      checks++; if (va !== 16'd12) begin errors++; $display("FAIL add_rf2: got %h exp 000c", va); end
      run_instr(3'd0, 3'd3, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 16'h0000, 2, 16'h0000, 1'b0);
      checks++; if (oa !== pc_exp || ob !== 16'd5) begin errors++; $display("FAIL pc_operand: got a %h b %h exp %h 0005", oa, ob, pc_exp); end
      pc_exp = pc_exp + 16'd1;
   endtask

   task automatic test_branch_wrap();
      logic [15:0] va, vb;
      run_instr(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000, 1, 16'hFFFF, 1'b0);
      checks++; if (pc !== 16'hFFFF) begin errors++; $display("FAIL branch_to_ffff: got %h exp ffff", pc); end
      run_instr(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 0, 16'h1234, 1'b0);
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL pc_wrap: got %h exp 0000", pc); end
      run_instr(3'd2, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000, 0, 16'h0040, 1'b0);
      checks++; if (pc !== 16'h0040) begin errors++; $display("FAIL branch_to_0040: got %h exp 0040", pc); end
      pc_exp = 16'h0040;
      read_reg(3'd2, va, vb);
      checks++; if (va !== 16'd12) begin errors++; $display("FAIL branch_no_wb: got %h exp 000c", va); end
   endtask

   task automatic test_bad_index();
      logic [15:0] va, vb;
      mem_data = 16'hABCD;
      run_instr(3'd6, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, 0, 16'h0000, 1'b0);
      pc_exp = pc_exp + 16'd1;
      read_reg(3'd6, va, vb);
      checks++; if (va !== 16'h0000) begin errors++; $display("FAIL idx6_read: got %h exp 0000", va); end
      read_reg(3'd7, va, vb);
      checks++; if (vb !== 16'h0000) begin errors++; $display("FAIL idx7_read: got %h exp 0000", vb); end
      read_reg(3'd0, va, vb);
      checks++; if (va !== 16'h0000) begin errors++; $display("FAIL idx6_no_alias: got %h exp 0000", va); end
      checks++; if (pc !== pc_exp) begin errors++; $display("FAIL idx_pc: got %h exp %h", pc, pc_exp); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] va, vb;
      mem_data = 16'h0101;
      run_instr(3'd4, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 16'h0000, 0, 16'h0000, 1'b0);
      checks++; if (rdy_end !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b exp 1", rdy_end); end
      run_instr(3'd5, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b100, 16'h0000, 1, 16'h0202, 1'b0);
      checks++; if (ret_wb !== 1'b1 || oop !== 3'b100) begin errors++; $display("FAIL b2b_second: retire %b op %h exp 1 4", ret_wb, oop); end
      pc_exp = pc_exp + 16'd2;
      read_reg(3'd4, va, vb);
      checks++; if (va !== 16'h0101) begin errors++; $display("FAIL b2b_rf4: got %h exp 0101", va); end
      read_reg(3'd5, va, vb);
      checks++; if (va !== 16'h0202) begin errors++; $display("FAIL b2b_rf5: got %h exp 0202", va); end
   endtask

`ifdef CPU_DP_EXU_TIMEOUT_EN
   task automatic test_timeout();
      logic [15:0] va, vb;
      int cnt;
      mem_data = 16'hABCD;
      rd_sel = 3'd2; rs1_sel = 3'd0; rs2_sel = 3'd0; r1_pc_sel = 1'b0; r2_ir_sel = 1'b0;
      pc_alu_sel = 1'b1; wb_src_sel = 1'b0; wb_en = 1'b1; alu_op = 3'd5; ir = 16'h0000;
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      cnt = (exu_req === 1'b1) ? 1 : 0;
      while (exu_req === 1'b1 && cnt < 20) begin
         @(posedge clk); #1;
         if (exu_req === 1'b1) cnt++;
      end
      checks++; if (cnt !== 8) begin errors++; $display("FAIL tmo_req_cycles: got %0d exp 8", cnt); end
      checks++; if (exu_timeout !== 1'b1 || retire !== 1'b1) begin errors++; $display("FAIL tmo_pulse: tmo %b retire %b exp 1 1", exu_timeout, retire); end
      exu_ack = 1'b1; exu_result = 16'h0F00;
      @(posedge clk); #1;
      exu_ack = 1'b0;
      checks++; if (exu_timeout !== 1'b0 || retire !== 1'b0 || exu_req !== 1'b0) begin errors++; $display("FAIL tmo_one_cycle: tmo %b retire %b req %b exp 0 0 0", exu_timeout, retire, exu_req); end
      checks++; if (pc !== pc_exp + 16'd1) begin errors++; $display("FAIL tmo_pc: got %h exp %h", pc, pc_exp + 16'd1); end
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0 || pc !== pc_exp + 16'd1) begin errors++; $display("FAIL tmo_late_ack: busy %b pc %h exp 0 %h", busy, pc, pc_exp + 16'd1); end
      pc_exp = pc_exp + 16'd1;
      read_reg(3'd2, va, vb);
      checks++; if (va !== 16'd12) begin errors++; $display("FAIL tmo_no_wb: got %h exp 000c", va); end
   endtask
`else
   task automatic test_exec_wait();
      logic [15:0] va, vb;
      run_instr(3'd4, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b011, 16'h0000, 20, 16'h0F0F, 1'b0);
      checks++; if (ostable !== 1'b1) begin errors++; $display("FAIL wait_stable: got %b exp 1", ostable); end
      checks++; if (ret_wb !== 1'b1) begin errors++; $display("FAIL wait_retire: got %b exp 1", ret_wb); end
      pc_exp = pc_exp + 16'd1;
      read_reg(3'd4, va, vb);
      checks++; if (va !== 16'h0F0F) begin errors++; $display("FAIL wait_rf4: got %h exp 0f0f", va); end
   endtask
`endif

   task automatic test_reset_mid_exec();
      logic [15:0] va, vb;
      mem_data = 16'h7777;
      rd_sel = 3'd1; rs1_sel = 3'd0; rs2_sel = 3'd0; r1_pc_sel = 1'b0; r2_ir_sel = 1'b0;
      pc_alu_sel = 1'b0; wb_src_sel = 1'b0; wb_en = 1'b1; alu_op = 3'd2; ir = 16'h0000;
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (exu_req !== 1'b1) begin errors++; $display("FAIL mid_req_before: got %b exp 1", exu_req); end
      #3;
      reset_n = 1'b0;
      #1;
      checks++; if (exu_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_async_drop: req %b busy %b exp 0 0", exu_req, busy); end
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL mid_pc: got %h exp 0000", pc); end
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      pc_exp = 16'h0000;
      read_reg(3'd1, va, vb);
      checks++; if (va !== 16'h0000) begin errors++; $display("FAIL mid_no_wb: got %h exp 0000", va); end
   endtask

   initial begin
      checks = 0; errors = 0; pc_exp = 16'h0000;
      reset_n = 1'b0; instr_valid = 1'b0; ir = '0; rd_sel = '0; rs1_sel = '0; rs2_sel = '0;
      r1_pc_sel = 1'b0; r2_ir_sel = 1'b0; pc_alu_sel = 1'b0; wb_src_sel = 1'b0; wb_en = 1'b0;
      alu_op = '0; exu_ack = 1'b0; exu_result = '0; mem_data = '0;
      test_reset();
      test_load();
      test_alu_add();
      test_branch_wrap();
      test_bad_index();
      test_back_to_back();
`ifdef CPU_DP_EXU_TIMEOUT_EN
      test_timeout();
`else
      test_exec_wait();
`endif
      test_reset_mid_exec();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
